life_gen_sched: RTL and testbench

Generation scheduler for the cellular-automaton board datapath. Decides when the board register loads a freshly seeded board (`load_init`) and when it advances one generation (`advance`): free-running at a selectable rate, paused, or single-stepped. Counts generations and halts automatically when the board dies out, stops changing, or the counter saturates. Sits beside the board register and drives its load/enable strobes in place of the raw `start` and free-running update.

---
 rtl/life_gen_sched.sv | 139 +++++++++++++
 tb/tb_life_gen_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/life_gen_sched.sv
// Generation scheduler for the cellular-automaton board: issues seed loads and
// generation advances (free-run, pause, single-step) and halts on empty/stable/limit.
module life_gen_sched #(
    parameter int DIV_BASE = 16,
    parameter int GEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             run,
    input  logic             step,
    input  logic [1:0]       speed,
    input  logic             board_empty,
    input  logic             board_same,
    output logic             load_init,
    output logic             advance,
    output logic [GEN_W-1:0] gen_count,
    output logic [2:0]       state,
    output logic [1:0]       halt_reason
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEED  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_PAUSE = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd4;

    localparam logic [1:0] HR_NONE   = 2'd0;
    localparam logic [1:0] HR_EMPTY  = 2'd1;
    localparam logic [1:0] HR_STABLE = 2'd2;
    localparam logic [1:0] HR_LIMIT  = 2'd3;

    localparam int               PRE_W        = $clog2(DIV_BASE * 8);
    localparam logic [PRE_W:0]   BASE         = (PRE_W + 1)'(DIV_BASE);
    localparam logic [GEN_W-1:0] GEN_PRE_LAST = {{(GEN_W - 1){1'b1}}, 1'b0};

    logic [2:0]       state_q, state_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic [GEN_W-1:0] gen_q, gen_d;
    logic [1:0]       reason_q, reason_d;
    logic             load_q, load_d;
    logic             adv_q, adv_d;

    logic [PRE_W:0]   period_m1;
    logic             tick;
    logic             accept;

    // Longest period is DIV_BASE*8; the extra top bit keeps the shift lossless.
    assign period_m1 = (BASE << (2'd3 - speed)) - (PRE_W + 1)'(1);
    // >= rather than == so switching to a shorter period mid-count fires at once.
    assign tick      = ({1'b0, presc_q} >= period_m1);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        presc_d  = presc_q;
        gen_d    = gen_q;
        reason_d = reason_q;
        load_d   = 1'b0;
        adv_d    = 1'b0;
        accept   = 1'b0;

        if (start) begin
            state_d  = ST_SEED;
            load_d   = 1'b1;
            gen_d    = '0;
            reason_d = HR_NONE;
            presc_d  = '0;
        end else begin
            case (state_q)
                ST_SEED: begin
                    state_d = run ? ST_RUN : ST_PAUSE;
                    presc_d = '0;
                end
                ST_RUN: begin
                    if (!run) begin
                        state_d = ST_PAUSE;
                        presc_d = '0;
                    end else if (tick) begin
                        presc_d = '0;
                        accept  = 1'b1;
                    end else begin
                        presc_d = presc_q + PRE_W'(1);
                    end
                end
                ST_PAUSE: begin
                    accept = step;
                    if (run) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                default: ;
            endcase

            // Board flags describe the board this advance is about to replace.
            if (accept) begin
                adv_d = 1'b1;
                gen_d = gen_q + GEN_W'(1);
                if (board_empty) begin
                    state_d  = ST_HALT;
                    reason_d = HR_EMPTY;
                end else if (board_same) begin
                    state_d  = ST_HALT;
                    reason_d = HR_STABLE;
                end else if (gen_q == GEN_PRE_LAST) begin
                    state_d  = ST_HALT;
                    reason_d = HR_LIMIT;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            presc_q  <= '0;
            gen_q    <= '0;
            reason_q <= HR_NONE;
            load_q   <= 1'b0;
            adv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            gen_q    <= gen_d;
            reason_q <= reason_d;
            load_q   <= load_d;
            adv_q    <= adv_d;
        end
    end

    assign load_init   = load_q;
    assign advance     = adv_q;
    assign gen_count   = gen_q;
    assign state       = state_q;
    assign halt_reason = reason_q;

endmodule

// File: tb/tb_life_gen_sched.sv
// Self-checking bench for life_gen_sched: per-cycle vector table, strobe scoreboard,
// and directed sequences for run rate, speed change, halts, start override, reset, limit.
module tb_life_gen_sched;

    logic        clk;
    logic        rst;
    logic        start, run, step, board_empty, board_same;
    logic [1:0]  speed;
    logic        load_init, advance;
    logic [15:0] gen_count;
    logic [2:0]  state;
    logic [1:0]  halt_reason;

    logic        l_start, l_run, l_step, l_empty, l_same;
    logic [1:0]  l_speed;
    logic        l_load, l_adv;
    logic [3:0]  l_gen;
    logic [2:0]  l_state;
    logic [1:0]  l_reason;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int l_adv_cnt  = 0;
    int l_load_cnt = 0;
    int l_last_adv = -1;

    typedef struct {
        int cyc;
        int gen;
    } exp_t;

    exp_t adv_q[$];
    int   load_q[$];
    exp_t mon_e;

    typedef struct packed {
        logic        start;
        logic        run;
        logic        step;
        logic        empty;
        logic        same;
        logic [2:0]  st;
        logic [15:0] gen;
        logic [1:0]  rsn;
        logic        adv;
        logic        load;
    } vec_t;

    vec_t vecs[19];

    life_gen_sched #(.DIV_BASE(16), .GEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .run(run), .step(step), .speed(speed),
        .board_empty(board_empty), .board_same(board_same),
        .load_init(load_init), .advance(advance), .gen_count(gen_count),
        .state(state), .halt_reason(halt_reason)
    );

    life_gen_sched #(.DIV_BASE(2), .GEN_W(4)) dut_l (
        .clk(clk), .rst(rst), .start(l_start), .run(l_run), .step(l_step), .speed(l_speed),
        .board_empty(l_empty), .board_same(l_same),
        .load_init(l_load), .advance(l_adv), .gen_count(l_gen),
        .state(l_state), .halt_reason(l_reason)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_adv(input int c, input int g);
        exp_t e;
        e.cyc = c;
        e.gen = g;
        adv_q.push_back(e);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    function automatic vec_t mk(input bit s, input bit r, input bit p, input bit e, input bit m,
                                input int st, input int gen, input int rsn, input bit a, input bit l);
        vec_t v;
        v.start = s;  v.run = r;  v.step = p;  v.empty = e;  v.same = m;
        v.st  = 3'(st);
        v.gen = 16'(gen);
        v.rsn = 2'(rsn);
        v.adv = a;  v.load = l;
        return v;
    endfunction

    // Scoreboard: every strobe must match the front of its expectation queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (advance) begin
                if (adv_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_advance: got advance=1 at cycle %0d, expected 0", cyc);
                end else begin
                    mon_e = adv_q.pop_front();
                    check("advance_cycle", cyc, mon_e.cyc);
                    check("advance_gen", 32'(gen_count), mon_e.gen);
                end
            end
            if (load_init) begin
                if (load_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_load_init: got load_init=1 at cycle %0d, expected 0", cyc);
                end else begin
                    check("load_cycle", cyc, load_q.pop_front());
                    check("load_gen_zero", 32'(gen_count), 0);
                end
            end
            if (advance && load_init) begin
                n_checks++;
                n_fail++;
                $display("FAIL strobe_overlap: got advance=1 and load_init=1 at cycle %0d, expected at most one", cyc);
            end
            if (l_adv) begin
                l_adv_cnt  <= l_adv_cnt + 1;
                l_last_adv <= cyc;
            end
            if (l_load) l_load_cnt <= l_load_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int c;

        start = 0; run = 0; step = 0; board_empty = 0; board_same = 0; speed = 2'd3;
        l_start = 0; l_run = 0; l_step = 0; l_empty = 0; l_same = 0; l_speed = 2'd3;
        rst = 1'b1;

        // Columns: start run step empty same | state gen reason adv load
        vecs[0]  = mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        vecs[3]  = mk(0, 0, 1, 0, 0, 3, 1, 0, 1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
        vecs[5]  = mk(0, 0, 1, 0, 0, 3, 2, 0, 1, 0);
        vecs[6]  = mk(0, 1, 1, 0, 0, 2, 3, 0, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 3, 3, 0, 0, 0);
        vecs[8]  = mk(0, 0, 1, 0, 1, 4, 4, 2, 1, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 4, 4, 2, 0, 0);
        vecs[10] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[11] = mk(0, 0, 1, 1, 1, 3, 0, 0, 0, 0);
        vecs[12] = mk(0, 0, 1, 1, 1, 4, 1, 1, 1, 0);
        vecs[13] = mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 1);
        vecs[14] = mk(0, 1, 0, 1, 0, 2, 0, 0, 0, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);
        vecs[16] = mk(0, 0, 1, 1, 0, 4, 1, 1, 1, 0);
        vecs[17] = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1);
        vecs[18] = mk(0, 0, 0, 0, 0, 3, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_state", 32'(state), 0);
        check("rst_gen", 32'(gen_count), 0);
        check("rst_reason", 32'(halt_reason), 0);
        check("rst_advance", 32'(advance), 0);
        check("rst_load", 32'(load_init), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(state), 0);

        for (int i = 0; i < 19; i++) begin
            start = vecs[i].start;  run = vecs[i].run;  step = vecs[i].step;
            board_empty = vecs[i].empty;  board_same = vecs[i].same;
            if (vecs[i].adv)  expect_adv(cyc + 1, int'(vecs[i].gen));
            if (vecs[i].load) load_q.push_back(cyc + 1);
            @(negedge clk);
            check($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].st));
            check($sformatf("vec%0d_gen", i), 32'(gen_count), 32'(vecs[i].gen));
            check($sformatf("vec%0d_reason", i), 32'(halt_reason), 32'(vecs[i].rsn));
        end
        start = 0; run = 0; step = 0; board_empty = 0; board_same = 0;

        // Seed with run low, then 200 quiet cycles in PAUSE.
        c = cyc;
        start = 1;
        load_q.push_back(c + 1);
        @(negedge clk);
        start = 0;
        check("seed_state", 32'(state), 1);
        repeat (200) @(negedge clk);
        check("pause_hold_state", 32'(state), 3);
        check("pause_hold_gen", 32'(gen_count), 0);

        // Free-run at speed 3 (16 cycles), then speed 0 (128 cycles).
        c = cyc;
        run = 1;
        speed = 2'd3;
        for (int k = 1; k <= 10; k++) expect_adv(c + 1 + 16 * k, k);
        wait_until(c + 161);
        check("rate16_gen", 32'(gen_count), 10);
        check("rate16_state", 32'(state), 2);
        speed = 2'd0;
        expect_adv(c + 161 + 128, 11);
        expect_adv(c + 161 + 256, 12);
        wait_until(c + 417);
        check("rate128_gen", 32'(gen_count), 12);
        run = 0;
        @(negedge clk);
        check("run_low_pause", 32'(state), 3);

        // Shorten the period mid-count: tick fires at once, then a tick dropped by run falling.
        c = cyc;
        run = 1;
        speed = 2'd0;
        wait_until(c + 41);
        speed = 2'd3;
        expect_adv(c + 42, 13);
        expect_adv(c + 58, 14);
        wait_until(c + 73);
        run = 0;
        @(negedge clk);
        check("drop_tick_state", 32'(state), 3);
        check("drop_tick_gen", 32'(gen_count), 14);

        // Stable board at a RUN tick: advance issues, then HALT reason 2.
        c = cyc;
        run = 1;
        expect_adv(c + 17, 15);
        wait_until(c + 16);
        board_same = 1;
        @(negedge clk);
        board_same = 0;
        check("stable_halt_state", 32'(state), 4);
        check("stable_halt_reason", 32'(halt_reason), 2);
        check("stable_halt_gen", 32'(gen_count), 15);
        for (int k = 0; k < 3; k++) begin
            step = 1;
            @(negedge clk);
            step = 0;
            repeat (3) @(negedge clk);
        end
        check("halt_ignores_state", 32'(state), 4);
        check("halt_ignores_gen", 32'(gen_count), 15);
        run = 0;

        // Reseed into RUN; empty and stable together at a tick give reason 1.
        c = cyc;
        start = 1;
        run = 1;
        load_q.push_back(c + 1);
        @(negedge clk);
        start = 0;
        expect_adv(c + 18, 1);
        wait_until(c + 17);
        board_empty = 1;
        board_same = 1;
        @(negedge clk);
        board_empty = 0;
        board_same = 0;
        check("empty_halt_state", 32'(state), 4);
        check("empty_halt_reason", 32'(halt_reason), 1);
        check("empty_halt_gen", 32'(gen_count), 1);

        // Start on the cycle a tick is due: reseed wins, no advance.
        c = cyc;
        start = 1;
        load_q.push_back(c + 1);
        @(negedge clk);
        start = 0;
        wait_until(c + 17);
        start = 1;
        load_q.push_back(c + 18);
        @(negedge clk);
        start = 0;
        check("override_state", 32'(state), 1);
        check("override_gen", 32'(gen_count), 0);
        check("override_advance", 32'(advance), 0);
        expect_adv(c + 35, 1);
        wait_until(c + 35);
        check("pre_reset_advance", 32'(advance), 1);

        // Asynchronous reset between edges while advance is high.
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_state", 32'(state), 0);
        check("async_rst_gen", 32'(gen_count), 0);
        check("async_rst_advance", 32'(advance), 0);
        check("async_rst_load", 32'(load_init), 0);
        check("async_rst_reason", 32'(halt_reason), 0);
        run = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("post_rst_idle", 32'(state), 0);

        // Counter limit on the 4-bit instance: 15 advances, then HALT reason 3.
        c = cyc;
        l_start = 1;
        l_run = 1;
        l_speed = 2'd3;
        @(negedge clk);
        l_start = 0;
        repeat (40) @(negedge clk);
        check("limit_state", 32'(l_state), 4);
        check("limit_reason", 32'(l_reason), 3);
        check("limit_gen", 32'(l_gen), 15);
        check("limit_adv_count", l_adv_cnt, 15);
        check("limit_last_adv_cycle", l_last_adv, c + 32);
        check("limit_load_count", l_load_cnt, 1);

        check("adv_queue_left", adv_q.size(), 0);
        check("load_queue_left", load_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
